// File: rtl/md_sequencer_if.sv
// Execute-stage multiply/divide bus: issue controls and operands in, status and HI/LO out.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, md_op, A, B, md_use_D,
    input  busy, stall_md, HI, LO
  );

  modport slave (
    input  start, md_op, A, B, md_use_D,
    output busy, stall_md, HI, LO
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// The result is computed at issue and held in temporaries until the fixed latency expires.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  md_sequencer_if.slave md
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [31:0] hi_t_r, hi_t_nxt_s;
  logic [31:0] lo_t_r, lo_t_nxt_s;
  logic        dz_r, dz_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic        busy_r, busy_nxt_s;

  logic        is_signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [63:0] prod_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] b_div_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Two's-complement negate helper used for magnitude conversion and sign restore.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  // Signed ops sign-extend to 64 bits so one unsigned multiplier serves both flavours.
  assign is_signed_s = (md.md_op == OP_MULT) || (md.md_op == OP_DIV);
  assign a_neg_s     = is_signed_s & md.A[31];
  assign b_neg_s     = is_signed_s & md.B[31];
  assign prod_s      = {{32{a_neg_s}}, md.A} * {{32{b_neg_s}}, md.B};

  // Division on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign a_mag_s = a_neg_s ? neg32(md.A) : md.A;
  assign b_mag_s = b_neg_s ? neg32(md.B) : md.B;
  assign b_div_s = (md.B == 32'd0) ? 32'd1 : b_mag_s;
  assign q_mag_s = a_mag_s / b_div_s;
  assign r_mag_s = a_mag_s % b_div_s;
  assign quot_s  = (a_neg_s ^ b_neg_s) ? neg32(q_mag_s) : q_mag_s;
  assign rem_s   = a_neg_s ? neg32(r_mag_s) : r_mag_s;

  // Next-state and next-register logic for the IDLE/RUN sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    hi_t_nxt_s  = hi_t_r;
    lo_t_nxt_s  = lo_t_r;
    dz_nxt_s    = dz_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    busy_nxt_s  = busy_r;

    case (state_r)
      IDLE: begin
        if (md.start) begin
          case (md.md_op)
            OP_MULT, OP_MULTU: begin
              hi_t_nxt_s  = prod_s[63:32];
              lo_t_nxt_s  = prod_s[31:0];
              dz_nxt_s    = 1'b0;
              cnt_nxt_s   = MULT_CNT;
              busy_nxt_s  = 1'b1;
              state_nxt_s = RUN;
            end
            OP_DIV, OP_DIVU: begin
              hi_t_nxt_s  = rem_s;
              lo_t_nxt_s  = quot_s;
              dz_nxt_s    = (md.B == 32'd0);
              cnt_nxt_s   = DIV_CNT;
              busy_nxt_s  = 1'b1;
              state_nxt_s = RUN;
            end
            OP_MTHI: begin
              hi_nxt_s = md.A;
            end
            OP_MTLO: begin
              lo_nxt_s = md.A;
            end
            default: begin
              hi_nxt_s = hi_r;
            end
          endcase
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      RUN: begin
        // New starts are ignored here, including one landing on the final cycle.
        if (cnt_r == 4'd1) begin
          cnt_nxt_s   = 4'd0;
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
          if (!dz_r) begin
            hi_nxt_s = hi_t_r;
            lo_nxt_s = lo_t_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and architectural register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      hi_t_r  <= 32'd0;
      lo_t_r  <= 32'd0;
      dz_r    <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      hi_t_r  <= hi_t_nxt_s;
      lo_t_r  <= lo_t_nxt_s;
      dz_r    <= dz_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign md.busy     = busy_r;
  assign md.HI       = hi_r;
  assign md.LO       = lo_r;
  assign md.stall_md = md.md_use_D & (busy_r | (md.start & (md.md_op <= OP_DIVU)));

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: the driver pushes expected HI/LO from a 64-bit
// arithmetic model, the monitor tracks busy/stall timing and pops at each architectural update.
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk;
  logic reset;
  md_sequencer_if mdi();

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdi)
  );

  exp_t run_q[$];
  exp_t now_q[$];
  int checks;
  int failures;
  int use_mode;
  logic [31:0] arch_hi;
  logic [31:0] arch_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result of an op given current architectural HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, sq, sr;
    logic [63:0] t;
    sa = $signed(a);
    sb = $signed(b);
    hi = arch_hi;
    lo = arch_lo;
    case (op)
      3'd0: begin t = sa * sb; hi = t[63:32]; lo = t[31:0]; end
      3'd1: begin t = {32'd0, a} * {32'd0, b}; hi = t[63:32]; lo = t[31:0]; end
      3'd2: if (b != 32'd0) begin
              sq = sa / sb; sr = sa % sb;
              t = sq; lo = t[31:0];
              t = sr; hi = t[31:0];
            end
      3'd3: if (b != 32'd0) begin lo = a / b; hi = a % b; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mdi.start    = 1'b0;
    mdi.md_op    = 3'($urandom_range(0, 7));
    mdi.A        = $urandom;
    mdi.B        = $urandom;
    mdi.md_use_D = (use_mode < 0) ? 1'($urandom_range(0, 1)) : use_mode[0];
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    tick();
    mdi.start = 1'b1;
    mdi.md_op = op;
    mdi.A     = a;
    mdi.B     = b;
    model(op, a, b, e.hi, e.lo);
    arch_hi = e.hi;
    arch_lo = e.lo;
    if (op <= 3'd3) begin
      e.cycles = (op <= 3'd1) ? MC : DC;
      run_q.push_back(e);
      repeat (e.cycles) tick();
    end else begin
      e.cycles = 0;
      now_q.push_back(e);
    end
  endtask

  // Monitor: timing model for busy/stall and scoreboard pops on each HI/LO update.
  initial begin
    int   model_rem;
    bit   armed, now_flag, commit_flag;
    logic [31:0] cur_hi, cur_lo;
    exp_t e;
    model_rem = 0; armed = 0; now_flag = 0; commit_flag = 0;
    cur_hi = 32'd0; cur_lo = 32'd0;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (now_flag) begin
          if (now_q.size() == 0) chk("now_q_empty", 32'd1, 32'd0);
          else begin e = now_q.pop_front(); cur_hi = e.hi; cur_lo = e.lo; end
        end
        if (commit_flag) begin
          if (run_q.size() == 0) chk("run_q_empty", 32'd1, 32'd0);
          else begin e = run_q.pop_front(); cur_hi = e.hi; cur_lo = e.lo; end
        end
        chk("busy", {31'd0, mdi.busy}, {31'd0, model_rem > 0});
        chk("stall_md", {31'd0, mdi.stall_md},
            {31'd0, mdi.md_use_D & ((model_rem > 0) | (mdi.start & (mdi.md_op <= 3'd3)))});
        chk("HI", mdi.HI, cur_hi);
        chk("LO", mdi.LO, cur_lo);
      end
      now_flag = 0;
      commit_flag = 0;
      if (reset === 1'b0) begin
        armed = 1; model_rem = 0; cur_hi = 32'd0; cur_lo = 32'd0;
        run_q.delete(); now_q.delete();
      end else if (armed) begin
        if (model_rem > 0) begin
          chk("start_while_busy", {31'd0, mdi.start}, 32'd0);
          model_rem--;
          if (model_rem == 0) commit_flag = 1;
        end else if (mdi.start === 1'b1) begin
          if (mdi.md_op <= 3'd3) begin
            if (run_q.size() == 0) chk("issue_no_exp", 32'd1, 32'd0);
            else model_rem = run_q[0].cycles;
          end else begin
            now_flag = 1;
          end
        end
      end
    end
  end

  // Driver: directed cases followed by constrained-random traffic.
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    checks = 0; failures = 0; use_mode = -1;
    arch_hi = 32'd0; arch_lo = 32'd0;
    reset = 1'b1;
    mdi.start = 1'b0; mdi.md_op = 3'd7; mdi.A = 32'd0; mdi.B = 32'd0; mdi.md_use_D = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    use_mode = 1;
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    use_mode = 0;
    do_op(3'd0, 32'd1234, 32'hFFFF_0000);
    use_mode = -1;
    do_op(3'd3, 32'd7, 32'd2);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd4, 32'h0000_1234, 32'd0);
    do_op(3'd5, 32'h0000_5678, 32'd0);
    do_op(3'd2, 32'd100, 32'd0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    tick();
    mdi.start = 1'b1; mdi.md_op = 3'd1; mdi.A = 32'hFFFF_FFFF; mdi.B = 32'hFFFF_FFFF;
    run_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, cycles: MC});
    tick();
    tick();
    tick();
    reset = 1'b0;
    arch_hi = 32'd0; arch_lo = 32'd0;
    tick();
    reset = 1'b1;
    repeat (8) tick();

    use_mode = 1;
    do_op(3'd4, 32'hDEAD_BEEF, 32'd0);
    do_op(3'd5, 32'hCAFE_F00D, 32'd0);
    do_op(3'd6, 32'h1111_1111, 32'd3);
    use_mode = -1;

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      do_op(op, a, b);
      if ($urandom_range(0, 3) == 0) tick();
    end
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
